// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer: UART receive front end (start qualify, mid-bit sample, record push); UART_RX_MAJORITY_EN selects 2-of-3 sampling.
module uart_rx_deserializer #(
   parameter int SAMPLE_DIV = 16
) (
   input  logic        clk,
   input  logic        wb_rst_ni,
   input  logic        enable,
   input  logic        serial_in,
   input  logic [7:0]  lcr,
   input  logic        rx_reset,
   output logic [10:0] rec_data,
   output logic        rec_push,
   output logic [3:0]  rstate,
   output logic        busy
);
   localparam int CW = $clog2(SAMPLE_DIV);
   localparam int M  = SAMPLE_DIV / 2;
   localparam logic [CW-1:0] C_S0  = CW'(M - 1);
   localparam logic [CW-1:0] C_S1  = CW'(M);
   localparam logic [CW-1:0] C_DEC = CW'(M + 1);
   localparam logic [CW-1:0] C_END = CW'(SAMPLE_DIV - 1);
   localparam logic [3:0] IDLE = 4'd0, START = 4'd1, DATA = 4'd2, PARITY = 4'd3, STOP = 4'd4, WAIT_HIGH = 4'd5;

   logic [3:0]    r_state, w_next;
   logic [CW-1:0] r_cnt;
   logic [1:0]    r_s;
   logic [4:0]    r_lcr;
   logic [7:0]    r_shift;
   logic [3:0]    r_bits;
   logic          r_pe, r_zero;
   logic [10:0]   r_rec_data;
   logic          r_rec_push;
   logic          w_bit, w_dec, w_wrap, w_par_exp, w_unused;

`ifdef UART_RX_MAJORITY_EN
   assign w_bit    = (r_s[0] & r_s[1]) | (r_s[0] & serial_in) | (r_s[1] & serial_in);
   assign w_unused = ^{lcr[7:6], lcr[2]};
`else
   assign w_bit    = r_s[1];
   assign w_unused = ^{lcr[7:6], lcr[2], r_s[0]};
`endif

   assign w_dec  = enable && r_cnt == C_DEC;
   assign w_wrap = enable && r_cnt == C_END;
   // r_lcr packs {stick, even, parity_en, wl[1:0]}; unused data bits stay 0 so XOR covers the word
   assign w_par_exp = r_lcr[4] ? ~r_lcr[3] : (r_lcr[3] ? ^r_shift : ~^r_shift);

   always_ff @(posedge clk or negedge wb_rst_ni)
      if (!wb_rst_ni) r_state <= IDLE;
      else            r_state <= w_next;

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:      w_next = (enable && !serial_in) ? START : IDLE;
         START:     w_next = (w_dec && w_bit) ? IDLE : (w_wrap ? DATA : START);
         DATA:      w_next = (w_wrap && r_bits == 4'd5 + {2'b0, r_lcr[1:0]}) ? (r_lcr[2] ? PARITY : STOP) : DATA;
         PARITY:    w_next = w_wrap ? STOP : PARITY;
         STOP:      w_next = w_dec ? (w_bit ? IDLE : WAIT_HIGH) : STOP;
         WAIT_HIGH: w_next = (enable && serial_in) ? IDLE : WAIT_HIGH;
         default:   w_next = IDLE;
      endcase
      if (rx_reset) w_next = IDLE;
   end

   always_comb begin
      rstate   = r_state;
      busy     = r_state != IDLE;
      rec_data = r_rec_data;
      rec_push = r_rec_push;
   end

   always_ff @(posedge clk or negedge wb_rst_ni)
      if (!wb_rst_ni) begin
         r_cnt      <= '0;
         r_s        <= '0;
         r_lcr      <= 5'b00011;
         r_shift    <= '0;
         r_bits     <= '0;
         r_pe       <= 1'b0;
         r_zero     <= 1'b0;
         r_rec_data <= '0;
         r_rec_push <= 1'b0;
      end else if (rx_reset) begin
         r_cnt      <= '0;
         r_shift    <= '0;
         r_bits     <= '0;
         r_pe       <= 1'b0;
         r_zero     <= 1'b0;
         r_rec_push <= 1'b0;
      end else begin
         r_rec_push <= w_dec && r_state == STOP;
         if (w_dec && r_state == STOP) r_rec_data <= {r_shift, r_zero & ~w_bit, r_pe, ~w_bit};
         if (enable) begin
            r_cnt <= (w_next == IDLE) ? '0 : r_cnt + CW'(1);
            if (r_cnt == C_S0) r_s[0] <= serial_in;
            if (r_cnt == C_S1) r_s[1] <= serial_in;
            if (r_state == IDLE) begin
               r_shift <= '0;
               r_bits  <= '0;
               r_pe    <= 1'b0;
               r_zero  <= 1'b0;
            end
         end
         if (w_dec && r_state == START && !w_bit) begin
            r_lcr  <= {lcr[5:3], lcr[1:0]};
            r_zero <= 1'b1;
         end
         if (w_dec && r_state == DATA) begin
            r_shift[r_bits[2:0]] <= w_bit;
            r_bits               <= r_bits + 4'd1;
            r_zero               <= r_zero & ~w_bit;
         end
         if (w_dec && r_state == PARITY) begin
            r_pe   <= w_bit ^ w_par_exp;
            r_zero <= r_zero & ~w_bit;
         end
      end
endmodule

// File: doc/uart_rx_deserializer.md
# uart_rx_deserializer

Receive-side serial front end of the UART. It takes the synchronized, loopback-muxed RX line and the baud oversample tick generated by the register block. It performs start-bit qualification, mid-bit sampling, data/parity/stop extraction and break detection. Each received character is emitted as one 11-bit record with a single-cycle push pulse for the receive FIFO, which the register block reads back as `rf_data_out`.

## Interface
Parameters:
- SAMPLE_DIV, 16, enable ticks per bit time; power of two, ≥ 8. M = SAMPLE_DIV/2.

Ports:
- clk  in  1  system clock; the only clock.
- wb_rst_ni  in  1  asynchronous, active-low reset.
- enable  in  1  oversample tick, one clk wide, SAMPLE_DIV per bit time.
- serial_in  in  1  synchronized RX line; idle high.
- lcr  in  8  line control:
  - [1:0] word length, 5 + value bits
  - [3] parity enable
  - [4] even parity
  - [5] stick parity
  - [2] and [7:6] ignored
- rx_reset  in  1  synchronous abort of the frame in progress.
- rec_data  out  11  received record:
  - [10:3] data, LSB-aligned, unused upper bits 0
  - [2] break
  - [1] parity error
  - [0] framing error
- rec_push  out  1  one-cycle pulse; rec_data is valid in the same cycle.
- rstate  out  4  current state code.
- busy  out  1  high in every state except IDLE.

## Operation
- States and rstate codes: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, WAIT_HIGH=5.
- All state, counter and sample updates occur only on clk edges where enable=1, except rx_reset and rec_push deassertion.
- Bit counter `cnt`:
  - Set to 0 on the start-detect tick; increments every tick.
  - Wraps SAMPLE_DIV-1 → 0, which marks a bit boundary.
  - Samples are taken at cnt = M-1, M, M+1. The bit value is decided at cnt = M+1.
- IDLE: a tick with serial_in=0 → START, cnt=0.
- START: at the decision point:
  - Value 1 → IDLE (glitch; no record).
  - Value 0 → latch lcr into a shadow register. Go to DATA at the next wrap.
  - lcr changes after the latch have no effect on the current frame.
- DATA:
  - Shift LSB first into an 8-bit register.
  - After 5+lcr[1:0] bits → PARITY if parity is enabled, else STOP (at the next wrap).
- PARITY:
  - Expected bit: stick parity → ~lcr[4]; even → XOR of data; odd → ~XOR of data.
  - Mismatch sets the parity error bit.
- STOP:
  - Only the first stop bit is checked.
  - At the decision point rec_push=1 in the cycle after the tick, carrying the record.
  - Stop value 0 → framing error=1 and next state WAIT_HIGH.
  - Stop value 1 → IDLE immediately, so a new start can be detected in the remainder of the stop bit.
- Break:
  - Break=1 when start, all data bits, parity (if enabled) and stop all decided 0.
  - A break record is data=0, break=1, framing error=1, parity error as computed.
- WAIT_HIGH: the first tick with serial_in=1 → IDLE. No records are produced while waiting.
- rx_reset=1 → on the next clk:
  - state IDLE, cnt=0, shift register and error flags cleared.
  - No rec_push, regardless of enable.
  - rx_reset has priority over a coinciding push.

## Timing
- Reset (wb_rst_ni=0): rec_data=0, rec_push=0, rstate=0, busy=0, cnt=0, shadow lcr=0x03.
- rec_push is high for exactly one clk. It is never asserted on consecutive cycles.
- Latency: rec_push rises one clk after the enable tick at which cnt=M+1 in the stop bit. For 8N1 that tick is (9·SAMPLE_DIV + M + 1) ticks after the start-detect tick.
- rec_data holds its value until the next push or reset.
- Missing enable ticks stall the block; nothing advances without a tick.

## Configuration
- UART_RX_MAJORITY_EN defined: each bit value is the 2-of-3 majority of the samples at cnt=M-1, M, M+1.
- Macro undefined: the bit value is the single sample at cnt=M.
- In both builds the decision is taken at cnt=M+1, so latency is identical.

## Test plan
All scenarios use SAMPLE_DIV=16 and enable=1 every clk.
- 8N1 (lcr=0x03), send 0xA5 → one rec_push with rec_data=0x528 (data 0xA5, flags 000), 154 clks after the start-detect tick; rstate returns to 0.
- 7E1 (lcr=0x1A), send 0x41 with the parity bit forced wrong → rec_data=0x20A (data 0x41, PE=1); push timing unchanged.
- Line held low for 12 bit times with lcr=0x03 → exactly one push with rec_data=0x005 (data 0, break, FE); rstate=5 until the line goes high, then 0; no further pushes.
- Start glitch: low for 4 ticks, then high → no push; rstate returns 0→1→0.
- rx_reset pulsed during data bit 3, and rx_reset coinciding with the stop decision → no push; rstate=0 the next clk; the following 0x3C frame is received correctly.
- Majority check: a single-tick low glitch at cnt=M in a '1' data bit of 0xFF.
  - With UART_RX_MAJORITY_EN: data is 0xFF.
  - Without the macro: that bit reads 0.
